register_file_mp: RTL and testbench
===================================

# register_file_mp

Parametrised multi-ported register file for the pipelined datapath. It provides NREAD combinational read ports and NWRITE synchronous write ports over a DEPTH x WIDTH array, with register 0 optionally hardwired to zero. It includes a per-register busy scoreboard that the decode stage uses for hazard detection. It sits between decode (reads, claims) and writeback (writes) and replaces the single-issue two-read/one-write file.

## Interface
- WIDTH, 32, data width in bits
- DEPTH, 32, number of registers (power of two, at least 2)
- NREAD, 2, number of read ports (at least 1)
- NWRITE, 1, number of write ports (at least 1)
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and claims
- CLK  in  1  clock, all state updates on the rising edge
- nRST  in  1  reset, asynchronous, active-low
- rsel  in  NREAD x $clog2(DEPTH)  read address per port
- rdat  out  NREAD x WIDTH  read data per port
- rbusy  out  NREAD  busy bit of the register addressed by rsel[i]
- wen  in  NWRITE  write enable per port
- wsel  in  NWRITE x $clog2(DEPTH)  write address per port
- wdat  in  NWRITE x WIDTH  write data per port
- claim_en  in  1  mark register claim_sel busy (instruction issued with that destination)
- claim_sel  in  $clog2(DEPTH)  register to claim
- busy_vec  out  DEPTH  full scoreboard state
- wcollide  out  1  registered flag, pulses high for one cycle after two or more write ports target the same register

## Operation
- Reset sets every register, every busy bit and wcollide to 0. This means rdat = 0, rbusy = 0 and busy_vec = 0 while nRST is low.
- Write: on a rising edge, for each port j with wen[j] set, reg[wsel[j]] <= wdat[j]. If several ports target the same address, the highest port index wins. When that happens, wcollide is set for the following cycle only.
- If ZERO_REG = 1, writes to address 0 are discarded. This holds even when they collide with another port on address 0: no wcollide is raised for address 0.
- Read: rdat[i] = reg[rsel[i]] combinationally. When ZERO_REG = 1 and rsel[i] = 0, rdat[i] = 0.
- Scoreboard:
  - Any accepted write to register r clears busy[r].
  - claim_en with claim_sel = r sets busy[r].
  - A claim and a write to the same r in the same cycle leave busy[r] = 1, because the claim wins: a new producer was issued.
  - A claim to register 0 is ignored when ZERO_REG = 1.
  - rbusy[i] = busy[rsel[i]] as currently registered. The scoreboard has no bypass.
- A write to a register that is not busy is legal and clears nothing extra.
- Reset asserted mid-operation clears all state immediately. Writes or claims presented in the same cycle as reset release are not captured until the next rising edge with nRST high.

## Timing
- Read latency: 0 cycles, combinational from rsel.
- Write-to-read latency: 1 cycle without bypass. With bypass, the new value is visible in the same cycle (see Configuration).
- Claim-to-rbusy latency: 1 cycle. Write-to-busy-clear latency: 1 cycle.
- wcollide is valid for exactly 1 cycle after the colliding edge.
- There is no back-pressure: every write and every claim is accepted on the edge where it is presented.

## Configuration
- Macro: RF_BYPASS_EN.
- Defined: read ports forward same-cycle write data.
  - If any wen[j] is set with wsel[j] == rsel[i], then rdat[i] = wdat[j] of the highest such j.
  - Address 0 is excluded when ZERO_REG = 1.
  - rbusy[i] is not forwarded.
- Undefined: rdat always comes from the registered array. Decode then needs one extra stall cycle on a writeback read-after-write.

## Structure
- cpu_types_pkg holds the following, all consumed by decode and hazard logic:
  - word_t for WIDTH = 32
  - regbits_t = logic [4:0]
  - RF_DEPTH = 32
  - RF_NREAD
  - RF_NWRITE
- Sub-module rf_scoreboard contains the DEPTH busy bits, the claim/clear priority logic and the rbusy read muxes. The parent holds the array, write arbitration, bypass and wcollide.

## Test plan
- Reset then read all addresses: every rdat = 0, busy_vec = 0, wcollide = 0.
- Write port 0 to reg 5 = 0xDEADBEEF. Next cycle rsel[0] = 5 gives 0xDEADBEEF. With RF_BYPASS_EN, the same-cycle read also gives 0xDEADBEEF; without it, the same-cycle read gives 0.
- With NWRITE = 2, write reg 7 from both ports (0x11 on port 0, 0x22 on port 1): reg 7 = 0x22 and wcollide = 1 for one cycle only.
- Write 0xFFFFFFFF to reg 0 and claim reg 0: rdat = 0 and busy_vec[0] = 0.
- Claim reg 9: rbusy reads 1 next cycle. Write reg 9 and claim reg 9 in the same cycle: busy stays 1. A write alone then clears it one cycle later.
- Assert nRST mid-stream with reg 3 = 0x1234 and busy[3] = 1: outputs clear asynchronously, before the next edge, and reads return 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types and register-file sizing.
// Decode and hazard logic use these types and sizes. The register file also
// takes its default parameters from here.
package cpu_types_pkg;

   localparam int unsigned RF_WIDTH  = 32;
   localparam int unsigned RF_DEPTH  = 32;
   localparam int unsigned RF_NREAD  = 2;
   localparam int unsigned RF_NWRITE = 1;

   typedef logic [RF_WIDTH-1:0] word_t;
   typedef logic [4:0]          regbits_t;

endpackage

// File: rtl/register_file_mp_scoreboard.sv
// rf_scoreboard: per-register busy bits for decode hazard detection.
// A claim marks a register busy, and an accepted write clears it. When both
// hit the same register in one cycle, the claim wins, because a newer
// producer has just issued. rbusy reads the registered state with no bypass.
module rf_scoreboard
   import cpu_types_pkg::*;
#(
   parameter int unsigned DEPTH    = RF_DEPTH,
   parameter int unsigned NREAD    = RF_NREAD,
   parameter int unsigned ZERO_REG = 1,
   localparam int unsigned AW      = $clog2(DEPTH)
) (
   input  logic                       CLK,
   input  logic                       nRST,
   input  logic [DEPTH-1:0]           clear,
   input  logic                       claim_en,
   input  logic [AW-1:0]              claim_sel,
   input  logic [NREAD-1:0][AW-1:0]   rsel,
   output logic [NREAD-1:0]           rbusy,
   output logic [DEPTH-1:0]           busy_vec
);

   logic [DEPTH-1:0] claim_mask;

   // one-hot claim mask; register 0 cannot be claimed when hardwired
   always_comb begin
      claim_mask = '0;
      if (claim_en && !(ZERO_REG != 0 && claim_sel == '0))
         claim_mask[claim_sel] = 1'b1;
   end

   // busy state: clear accepted writes first, then apply the claim on top
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         busy_vec <= '0;
      else
         busy_vec <= (busy_vec & ~clear) | claim_mask;
   end

   // per-port busy lookup from the registered scoreboard
   always_comb begin
      rbusy = '0;
      for (int unsigned i = 0; i < NREAD; i++)
         rbusy[i] = busy_vec[rsel[i]];
   end

endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: DEPTH x WIDTH register file with NREAD combinational read
// ports and NWRITE synchronous write ports. When several ports write the same
// register, the highest port index wins. Register 0 can be hardwired to zero.
// The busy scoreboard lives in rf_scoreboard.
// Optional feature macro: RF_BYPASS_EN forwards same-cycle write data to reads.
module register_file_mp
   import cpu_types_pkg::*;
#(
   parameter int unsigned WIDTH    = RF_WIDTH,
   parameter int unsigned DEPTH    = RF_DEPTH,
   parameter int unsigned NREAD    = RF_NREAD,
   parameter int unsigned NWRITE   = RF_NWRITE,
   parameter int unsigned ZERO_REG = 1,
   localparam int unsigned AW      = $clog2(DEPTH)
) (
   input  logic                        CLK,
   input  logic                        nRST,
   input  logic [NREAD-1:0][AW-1:0]    rsel,
   output logic [NREAD-1:0][WIDTH-1:0] rdat,
   output logic [NREAD-1:0]            rbusy,
   input  logic [NWRITE-1:0]           wen,
   input  logic [NWRITE-1:0][AW-1:0]   wsel,
   input  logic [NWRITE-1:0][WIDTH-1:0] wdat,
   input  logic                        claim_en,
   input  logic [AW-1:0]               claim_sel,
   output logic [DEPTH-1:0]            busy_vec,
   output logic                        wcollide
);

   logic [WIDTH-1:0]  regs [DEPTH];
   logic [NWRITE-1:0] wacc;
   logic [DEPTH-1:0]  wr_mask;
   logic              collide;

   // a write is accepted unless it targets the hardwired zero register
   always_comb begin
      wacc    = '0;
      wr_mask = '0;
      for (int unsigned j = 0; j < NWRITE; j++) begin
         wacc[j] = wen[j] && !(ZERO_REG != 0 && wsel[j] == '0);
         if (wacc[j])
            wr_mask[wsel[j]] = 1'b1;
      end
   end

   // collision: two accepted writes to the same register on this edge
   always_comb begin
      collide = 1'b0;
      for (int unsigned j = 0; j < NWRITE; j++)
         for (int unsigned k = j + 1; k < NWRITE; k++)
            if (wacc[j] && wacc[k] && wsel[j] == wsel[k])
               collide = 1'b1;
   end

   // array update; later ports overwrite earlier ones, so the highest index wins
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int unsigned r = 0; r < DEPTH; r++)
            regs[r] <= '0;
      end else begin
         for (int unsigned j = 0; j < NWRITE; j++)
            if (wacc[j])
               regs[wsel[j]] <= wdat[j];
      end
   end

   // single-cycle collision flag
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         wcollide <= 1'b0;
      else
         wcollide <= collide;
   end

   // read muxes, with optional forwarding of the highest matching write port
   always_comb begin
      rdat = '0;
      for (int unsigned i = 0; i < NREAD; i++) begin
         rdat[i] = regs[rsel[i]];
`ifdef RF_BYPASS_EN
         for (int unsigned j = 0; j < NWRITE; j++)
            if (wacc[j] && wsel[j] == rsel[i])
               rdat[i] = wdat[j];
`endif
         if (ZERO_REG != 0 && rsel[i] == '0)
            rdat[i] = '0;
      end
   end

   rf_scoreboard #(
      .DEPTH    (DEPTH),
      .NREAD    (NREAD),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .CLK       (CLK),
      .nRST      (nRST),
      .clear     (wr_mask),
      .claim_en  (claim_en),
      .claim_sel (claim_sel),
      .rsel      (rsel),
      .rbusy     (rbusy),
      .busy_vec  (busy_vec)
   );

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp (2 read ports, 2 write ports, zero reg).
// Directed table vectors, a reset-mid-stream sequence, then randomized traffic
// checked against an array-based reference model.
module tb_register_file_mp;

`ifdef RF_BYPASS_EN
   localparam bit BP = 1'b1;
`else
   localparam bit BP = 1'b0;
`endif

   logic              CLK;
   logic              nRST;
   logic [1:0][4:0]   rsel;
   logic [1:0][31:0]  rdat;
   logic [1:0]        rbusy;
   logic [1:0]        wen;
   logic [1:0][4:0]   wsel;
   logic [1:0][31:0]  wdat;
   logic              claim_en;
   logic [4:0]        claim_sel;
   logic [31:0]       busy_vec;
   logic              wcollide;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   register_file_mp #(
      .WIDTH    (32),
      .DEPTH    (32),
      .NREAD    (2),
      .NWRITE   (2),
      .ZERO_REG (1)
   ) dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .rsel      (rsel),
      .rdat      (rdat),
      .rbusy     (rbusy),
      .wen       (wen),
      .wsel      (wsel),
      .wdat      (wdat),
      .claim_en  (claim_en),
      .claim_sel (claim_sel),
      .busy_vec  (busy_vec),
      .wcollide  (wcollide)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // reference model state
   logic [31:0] mregs [32];
   logic [31:0] mbusy;
   logic        mcoll;

   typedef struct {
      logic [1:0]  wen;
      logic [4:0]  ws0;
      logic [31:0] wd0;
      logic [4:0]  ws1;
      logic [31:0] wd1;
      logic        cen;
      logic [4:0]  csel;
      logic [4:0]  rs0;
      logic [4:0]  rs1;
      logic [31:0] er0;
      logic [31:0] er1;
      logic [1:0]  erb;
      logic [31:0] ebv;
      logic        ecoll;
   } vec_t;

   vec_t tv [13];

   function automatic vec_t mk(logic [1:0] w, logic [4:0] s0, logic [31:0] d0,
                               logic [4:0] s1, logic [31:0] d1, logic ce, logic [4:0] cs,
                               logic [4:0] r0, logic [4:0] r1, logic [31:0] e0,
                               logic [31:0] e1, logic [1:0] eb, logic [31:0] ebv, logic ec);
      vec_t v;
      v.wen = w; v.ws0 = s0; v.wd0 = d0; v.ws1 = s1; v.wd1 = d1;
      v.cen = ce; v.csel = cs; v.rs0 = r0; v.rs1 = r1;
      v.er0 = e0; v.er1 = e1; v.erb = eb; v.ebv = ebv; v.ecoll = ec;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] w, input logic [4:0] s0, input logic [31:0] d0,
                        input logic [4:0] s1, input logic [31:0] d1, input logic ce,
                        input logic [4:0] cs, input logic [4:0] r0, input logic [4:0] r1);
      wen = w; wsel[0] = s0; wdat[0] = d0; wsel[1] = s1; wdat[1] = d1;
      claim_en = ce; claim_sel = cs; rsel[0] = r0; rsel[1] = r1;
   endtask

   task automatic model_reset();
      for (int r = 0; r < 32; r++) mregs[r] = '0;
      mbusy = '0;
      mcoll = 1'b0;
   endtask

   // expected read value: register 0 is zero, otherwise optional forwarding
   function automatic logic [31:0] model_read(input logic [4:0] a);
      if (a == 0) return '0;
      if (BP)
         for (int j = 1; j >= 0; j--)
            if (wen[j] && wsel[j] == a) return wdat[j];
      return mregs[a];
   endfunction

   // apply one rising edge's worth of architectural effects to the model
   task automatic model_tick();
      int hits [32];
      for (int r = 0; r < 32; r++) hits[r] = 0;
      for (int j = 0; j < 2; j++)
         if (wen[j] && wsel[j] != 0) begin
            hits[wsel[j]]++;
            mregs[wsel[j]] = wdat[j];
            mbusy[wsel[j]] = 1'b0;
         end
      if (claim_en && claim_sel != 0) mbusy[claim_sel] = 1'b1;
      mcoll = 1'b0;
      for (int r = 0; r < 32; r++)
         if (hits[r] >= 2) mcoll = 1'b1;
   endtask

   task automatic cycle();
      model_tick();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   initial begin
      tv[0]  = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd5, 5'd0,
                  32'h0, 32'h0, 2'b00, 32'h0, 1'b0);
      tv[1]  = mk(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,  1'b0, 5'd0, 5'd5, 5'd5,
                  BP ? 32'hDEADBEEF : 32'h0, BP ? 32'hDEADBEEF : 32'h0, 2'b00, 32'h0, 1'b0);
      tv[2]  = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd5, 5'd7,
                  32'hDEADBEEF, 32'h0, 2'b00, 32'h0, 1'b0);
      tv[3]  = mk(2'b11, 5'd7, 32'h11,       5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd5,
                  BP ? 32'h22 : 32'h0, 32'hDEADBEEF, 2'b00, 32'h0, 1'b0);
      tv[4]  = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 5'd5,
                  32'h22, 32'hDEADBEEF, 2'b00, 32'h0, 1'b1);
      tv[5]  = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 5'd5,
                  32'h22, 32'hDEADBEEF, 2'b00, 32'h0, 1'b0);
      tv[6]  = mk(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0,  1'b1, 5'd0, 5'd0, 5'd7,
                  32'h0, 32'h22, 2'b00, 32'h0, 1'b0);
      tv[7]  = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 5'd0,
                  32'h0, 32'h0, 2'b00, 32'h0, 1'b0);
      tv[8]  = mk(2'b11, 5'd0, 32'h1,        5'd0, 32'h2,  1'b0, 5'd0, 5'd0, 5'd5,
                  32'h0, 32'hDEADBEEF, 2'b00, 32'h0, 1'b0);
      tv[9]  = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b1, 5'd9, 5'd9, 5'd0,
                  32'h0, 32'h0, 2'b00, 32'h0, 1'b0);
      tv[10] = mk(2'b01, 5'd9, 32'h99,       5'd0, 32'h0,  1'b1, 5'd9, 5'd9, 5'd9,
                  BP ? 32'h99 : 32'h0, BP ? 32'h99 : 32'h0, 2'b11, 32'h200, 1'b0);
      tv[11] = mk(2'b01, 5'd9, 32'hAA,       5'd0, 32'h0,  1'b0, 5'd0, 5'd9, 5'd7,
                  BP ? 32'hAA : 32'h99, 32'h22, 2'b01, 32'h200, 1'b0);
      tv[12] = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd9, 5'd7,
                  32'hAA, 32'h22, 2'b00, 32'h0, 1'b0);

      // reset state
      nRST = 1'b0;
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd9);
      model_reset();
      #12;
      check("reset rdat0", rdat[0], 32'h0);
      check("reset rdat1", rdat[1], 32'h0);
      check("reset rbusy", {30'h0, rbusy}, 32'h0);
      check("reset busy_vec", busy_vec, 32'h0);
      check("reset wcollide", {31'h0, wcollide}, 32'h0);
      @(negedge CLK);
      nRST = 1'b1;

      // directed vectors: outputs checked before the edge that applies the inputs
      for (int v = 0; v < 13; v++) begin
         drive(tv[v].wen, tv[v].ws0, tv[v].wd0, tv[v].ws1, tv[v].wd1,
               tv[v].cen, tv[v].csel, tv[v].rs0, tv[v].rs1);
         #1;
         check($sformatf("vec%0d rdat0", v), rdat[0], tv[v].er0);
         check($sformatf("vec%0d rdat1", v), rdat[1], tv[v].er1);
         check($sformatf("vec%0d rbusy", v), {30'h0, rbusy}, {30'h0, tv[v].erb});
         check($sformatf("vec%0d busy_vec", v), busy_vec, tv[v].ebv);
         check($sformatf("vec%0d wcollide", v), {31'h0, wcollide}, {31'h0, tv[v].ecoll});
         cycle();
      end

      // reset asserted mid-stream clears state before the next edge
      drive(2'b01, 5'd3, 32'h1234, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd3);
      cycle();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3);
      #1;
      check("pre-reset rdat0", rdat[0], 32'h1234);
      check("pre-reset rbusy", {30'h0, rbusy}, 32'h3);
      check("pre-reset busy_vec", busy_vec, 32'h8);
      #1 nRST = 1'b0;
      #1;
      check("async reset rdat0", rdat[0], 32'h0);
      check("async reset rbusy", {30'h0, rbusy}, 32'h0);
      check("async reset busy_vec", busy_vec, 32'h0);
      model_reset();
      @(negedge CLK);
      // write presented in the release cycle lands on the next edge
      drive(2'b01, 5'd4, 32'h55, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd3);
      nRST = 1'b1;
      cycle();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd3);
      #1;
      check("post-release rdat0", rdat[0], 32'h55);
      check("post-release rdat1", rdat[1], 32'h0);

      // randomized traffic against the reference model
      for (int c = 0; c < 400; c++) begin
         drive(2'($urandom_range(0, 3)),
               5'($urandom_range(0, 7)), $urandom,
               5'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
               5'((c % 2 == 0) ? $urandom_range(0, 7) : $urandom_range(0, 31)),
               5'($urandom_range(0, 7)));
         #1;
         for (int i = 0; i < 2; i++) begin
            check($sformatf("rand%0d rdat%0d", c, i), rdat[i], model_read(rsel[i]));
            check($sformatf("rand%0d rbusy%0d", c, i), {31'h0, rbusy[i]},
                  {31'h0, mbusy[rsel[i]]});
         end
         check($sformatf("rand%0d busy_vec", c), busy_vec, mbusy);
         check($sformatf("rand%0d wcollide", c), {31'h0, wcollide}, {31'h0, mcoll});
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
